// File: rtl/uart_line_fifo.sv
// -----------------------------------------------------------------------------
// uart_line_fifo
//
// Line-buffering byte FIFO in the UART echo path, between uart_rx and
// rot13 / uart_tx. Received bytes are stored, but they are only released
// downstream after a complete line is stored. A line is complete when its
// terminator byte (TERM) is in the FIFO. This keeps retransmitted lines whole.
//
// If the FIFO fills with no terminator stored, no line can ever complete.
// In that case the FIFO switches to a drain mode that releases every stored
// byte. It also raises the sticky overflow flag.
//
// Both sides use the valid/ready byte handshake of the UART modules.
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   s_data    byte from uart_rx
//   s_valid   s_data is valid
//   s_ready   FIFO accepts a byte this cycle (not full)
//   m_data    oldest stored byte, toward rot13/uart_tx
//   m_valid   m_data is valid and released
//   m_ready   downstream consumes m_data this cycle
//   count     bytes currently stored, 0..DEPTH
//   lines     terminator bytes currently stored
//   overflow  sticky: a forced flush has happened since reset
// -----------------------------------------------------------------------------
module uart_line_fifo #(
  parameter int          DEPTH  = 16,
  parameter int          ADDR_W = 4,
  parameter logic [7:0]  TERM   = 8'h0D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   lines,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   ZERO_CNT = '0;
  localparam logic [ADDR_W-1:0] ONE_PTR  = (ADDR_W)'(1);

  // FILL: hold bytes until a full line is stored.
  // DRAIN: release every byte after a forced flush.
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t state, state_nxt;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_r, lines_r;
  logic              overflow_r;

  logic              wr, rd;
  logic              term_wr, term_rd;
  logic              force_flush;

  // Handshake decode. s_ready depends only on the registered count, so a
  // full FIFO refuses a write even in a cycle where a read also happens.
  assign s_ready  = (count_r != FULL_CNT);
  assign wr       = s_valid && s_ready;
  assign rd       = m_valid && m_ready;
  assign m_data   = mem[rd_ptr];
  assign term_wr  = wr && (s_data == TERM);
  assign term_rd  = rd && (m_data == TERM);

  assign count    = count_r;
  assign lines    = lines_r;
  assign overflow = overflow_r;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        // Full and no terminator stored: no line can complete, so flush.
        if ((count_r == FULL_CNT) && (lines_r == ZERO_CNT)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Leave at the edge where the last stored byte is consumed.
        if (rd && !wr && (count_r == ONE_CNT)) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    m_valid = 1'b0;
    case (state)
      FILL:    m_valid = (count_r != ZERO_CNT) && (lines_r != ZERO_CNT);
      DRAIN:   m_valid = (count_r != ZERO_CNT);
      default: m_valid = 1'b0;
    endcase
  end

  assign force_flush = (state == FILL) && (state_nxt == DRAIN);

  // Control registers: pointers, occupancy, line count, sticky flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      lines_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + ONE_PTR;
      end
      if (rd) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end

      case ({wr, rd})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase

      // A terminator written and another read in the same cycle cancel out.
      case ({term_wr, term_rd})
        2'b10:   lines_r <= lines_r + ONE_CNT;
        2'b01:   lines_r <= lines_r - ONE_CNT;
        default: lines_r <= lines_r;
      endcase

      if (force_flush) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Byte storage: data only, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= s_data;
    end
  end

endmodule

// File: tb/tb_uart_line_fifo.sv
module tb_uart_line_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] count;
  logic [4:0] lines;
  logic       overflow;

  int n_chk = 0;
  int n_bad = 0;

  uart_line_fifo #(.DEPTH(16), .ADDR_W(4), .TERM(8'h0D)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .count    (count),
    .lines    (lines),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  // Read expected bytes one per cycle with m_ready held high.
  task automatic pull(input string tag, input logic [7:0] b);
    m_ready = 1'b1;
    chk({tag, "_vld"}, m_valid, 1);
    chk({tag, "_dat"}, m_data, b);
    tick();
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (count == 0) break;
      tick();
    end
    chk({tag, "_empty"}, count, 0);
  endtask

  initial begin
    rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_srdy", s_ready, 1);
    chk("rst_mvld", m_valid, 0);
    chk("rst_cnt", count, 0);
    chk("rst_lines", lines, 0);
    chk("rst_ovf", overflow, 0);

    // basic line "AB\r"
    m_ready = 1'b1;
    put(8'h41);
    chk("ab_mvld1", m_valid, 0);
    chk("ab_cnt1", count, 1);
    put(8'h42);
    chk("ab_mvld2", m_valid, 0);
    chk("ab_cnt2", count, 2);
    put(8'h0D);
    chk("ab_lines", lines, 1);
    chk("ab_cnt3", count, 3);
    pull("ab_o0", 8'h41);
    pull("ab_o1", 8'h42);
    pull("ab_o2", 8'h0D);
    chk("ab_end_vld", m_valid, 0);
    chk("ab_end_cnt", count, 0);
    chk("ab_end_lines", lines, 0);

    // fill with no terminator -> forced flush
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) put(8'h30 + 8'(i));
    s_valid = 1'b1; s_data = 8'h40;   // 17th byte offered
    chk("full_cnt", count, 16);
    chk("full_srdy", s_ready, 0);
    chk("full_ovf0", overflow, 0);
    tick();
    chk("drn_vld", m_valid, 1);
    chk("drn_ovf", overflow, 1);
    chk("drn_cnt", count, 16);
    s_valid = 1'b0;
    for (int i = 0; i < 16; i++) pull("drn", 8'h30 + 8'(i));
    chk("drn_end_vld", m_valid, 0);
    chk("drn_end_cnt", count, 0);
    // back in FILL: an unterminated byte must be withheld
    put(8'h55);
    chk("fill_again_vld", m_valid, 0);
    chk("fill_again_cnt", count, 1);
    put(8'h0D);
    pull("fa0", 8'h55);
    pull("fa1", 8'h0D);
    chk("fa_end_vld", m_valid, 0);

    // concurrent read/write while the only line drains
    m_ready = 1'b0;
    put(8'h58);
    put(8'h0D);
    chk("cc_vld", m_valid, 1);
    chk("cc_dat", m_data, 8'h58);
    s_valid = 1'b1; s_data = 8'h59; m_ready = 1'b1;
    tick();
    chk("cc_cnt1", count, 2);
    chk("cc_lines1", lines, 1);
    chk("cc_dat1", m_data, 8'h0D);
    tick();
    chk("cc_cnt2", count, 2);
    chk("cc_lines2", lines, 0);
    chk("cc_vld2", m_valid, 0);
    s_valid = 1'b0;
    tick();
    chk("cc_hold_vld", m_valid, 0);
    chk("cc_hold_cnt", count, 2);
    put(8'h0D);
    chk("cc_lines3", lines, 1);
    pull("cc_o0", 8'h59);
    pull("cc_o1", 8'h59);
    pull("cc_o2", 8'h0D);
    chk("cc_end_vld", m_valid, 0);
    chk("sticky_ovf", overflow, 1);

    // pointers now at 10; two 2-byte lines bring them to 14
    m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      put(8'h5A);
      put(8'h0D);
      wait_empty("adv");
    end
    tick();
    // "ABCD\r" wraps through index 0
    m_ready = 1'b0;
    put(8'h41); put(8'h42); put(8'h43); put(8'h44); put(8'h0D);
    chk("wr_cnt", count, 5);
    chk("wr_lines", lines, 1);
    pull("wr_o0", 8'h41);
    pull("wr_o1", 8'h42);
    pull("wr_o2", 8'h43);
    pull("wr_o3", 8'h44);
    pull("wr_o4", 8'h0D);
    chk("wr_end_vld", m_valid, 0);
    chk("wr_end_cnt", count, 0);

    // reset mid-line discards the partial line
    m_ready = 1'b0;
    put(8'h41);
    put(8'h42);
    chk("mr_cnt_pre", count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_cnt", count, 0);
    chk("mr_lines", lines, 0);
    chk("mr_ovf", overflow, 0);
    chk("mr_vld", m_valid, 0);
    put(8'h43);
    put(8'h0D);
    pull("mr_o0", 8'h43);
    pull("mr_o1", 8'h0D);
    chk("mr_end_vld", m_valid, 0);
    chk("mr_end_cnt", count, 0);
    chk("mr_end_lines", lines, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
